tug_scoreboard: RTL and testbench

Match controller for the two-player tug-of-war game. It counts round wins per player from the playfield's win flags and drives each player's 3-bit score into that player's 7-segment score decoder. After each won round it pulses a playfield reset, and it declares a match winner when a score reaches MAX_SCORE. It sits between the playfield/LFSR logic and the two per-player HEX score decoders.

---
 rtl/tug_scoreboard_pkg.sv | 16 +
 rtl/tug_scoreboard_if.sv | 28 ++
 rtl/tug_scoreboard_rise_detect.sv | 21 ++
 rtl/tug_scoreboard.sv | 150 +++++++++++++++
 tb/tb_tug_scoreboard.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tug_scoreboard_pkg.sv
// Shared types and constants for the tug-of-war match controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        HOLD       = 2'd1,
        MATCH_OVER = 2'd2
    } state_t;

    localparam int   SCORE_W      = 3;
    localparam logic PLAYER_LEFT  = 1'b0;
    localparam logic PLAYER_RIGHT = 1'b1;

endpackage

// File: rtl/tug_scoreboard_if.sv
// Playfield-to-scoreboard bundle: win flags in, scores and match status out.
// Latency: n/a (wires only). Optional new_match exists under TUG_SCOREBOARD_NEW_MATCH_EN.
// Backpressure: none; all signals are plain levels or pulses.
interface tug_scoreboard_if;
    import tug_pkg::*;

    logic               left_win;
    logic               right_win;
    logic [SCORE_W-1:0] left_score;
    logic [SCORE_W-1:0] right_score;
    logic               round_reset;
    logic               match_over;
    logic               winner;
`ifdef TUG_SCOREBOARD_NEW_MATCH_EN
    logic               new_match;

    modport master (output left_win, right_win, new_match,
                    input  left_score, right_score, round_reset, match_over, winner);
    modport slave  (input  left_win, right_win, new_match,
                    output left_score, right_score, round_reset, match_over, winner);
`else
    modport master (output left_win, right_win,
                    input  left_score, right_score, round_reset, match_over, winner);
    modport slave  (input  left_win, right_win,
                    output left_score, right_score, round_reset, match_over, winner);
`endif

endinterface

// File: rtl/tug_scoreboard_rise_detect.sv
// Rising-edge detector: pulse is high for the cycle where in=1 and was 0 last cycle.
// Latency: combinational pulse, history register updates every cycle.
// Backpressure: none.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic r_prev;

    // Remember last cycle's level regardless of controller state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= in;
    end

    assign pulse = in & ~r_prev;

endmodule

// File: rtl/tug_scoreboard.sv
// Match controller: counts round wins, pulses round_reset, declares a match winner.
// Latency: win edge at cycle t -> score/round_reset update visible at t+1.
// Backpressure: none; edges during HOLD/MATCH_OVER are dropped. Macro TUG_SCOREBOARD_NEW_MATCH_EN adds new_match.
module tug_scoreboard
    import tug_pkg::*;
#(
    parameter int MAX_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    tug_scoreboard_if.slave bus
);

    localparam int                 HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] MAX_S     = SCORE_W'(MAX_SCORE);

    state_t             r_state,       w_state_nxt;
    logic [SCORE_W-1:0] r_left_score,  w_left_score_nxt;
    logic [SCORE_W-1:0] r_right_score, w_right_score_nxt;
    logic [HOLD_W-1:0]  r_hold,        w_hold_nxt;
    logic               r_round_reset, w_round_reset_nxt;
    logic               r_match_over,  w_match_over_nxt;
    logic               r_winner,      w_winner_nxt;

    logic               w_left_edge;
    logic               w_right_edge;
    logic [SCORE_W-1:0] w_left_inc;
    logic [SCORE_W-1:0] w_right_inc;

    rise_detect u_left_rise (
        .clk   (clk),
        .reset (reset),
        .in    (bus.left_win),
        .pulse (w_left_edge)
    );

    rise_detect u_right_rise (
        .clk   (clk),
        .reset (reset),
        .in    (bus.right_win),
        .pulse (w_right_edge)
    );

    // Cannot wrap: MATCH_OVER is entered as soon as a score reaches MAX_S.
    assign w_left_inc  = r_left_score  + SCORE_W'(1);
    assign w_right_inc = r_right_score + SCORE_W'(1);

    // State and all output-facing registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= PLAY;
            r_left_score  <= '0;
            r_right_score <= '0;
            r_hold        <= '0;
            r_round_reset <= 1'b0;
            r_match_over  <= 1'b0;
            r_winner      <= PLAYER_LEFT;
        end else begin
            r_state       <= w_state_nxt;
            r_left_score  <= w_left_score_nxt;
            r_right_score <= w_right_score_nxt;
            r_hold        <= w_hold_nxt;
            r_round_reset <= w_round_reset_nxt;
            r_match_over  <= w_match_over_nxt;
            r_winner      <= w_winner_nxt;
        end
    end

    // Next-state: score on a single edge, tie on a double edge, time out HOLD.
    always_comb begin
        w_state_nxt       = r_state;
        w_left_score_nxt  = r_left_score;
        w_right_score_nxt = r_right_score;
        w_hold_nxt        = r_hold;
        w_round_reset_nxt = r_round_reset;
        w_match_over_nxt  = r_match_over;
        w_winner_nxt      = r_winner;

        case (r_state)
            PLAY: begin
                if (w_left_edge && w_right_edge) begin
                    w_round_reset_nxt = 1'b1;
                    w_hold_nxt        = HOLD_INIT;
                    w_state_nxt       = HOLD;
                end else if (w_left_edge) begin
                    w_left_score_nxt  = w_left_inc;
                    w_round_reset_nxt = 1'b1;
                    if (w_left_inc == MAX_S) begin
                        w_match_over_nxt = 1'b1;
                        w_winner_nxt     = PLAYER_LEFT;
                        w_state_nxt      = MATCH_OVER;
                    end else begin
                        w_hold_nxt  = HOLD_INIT;
                        w_state_nxt = HOLD;
                    end
                end else if (w_right_edge) begin
                    w_right_score_nxt = w_right_inc;
                    w_round_reset_nxt = 1'b1;
                    if (w_right_inc == MAX_S) begin
                        w_match_over_nxt = 1'b1;
                        w_winner_nxt     = PLAYER_RIGHT;
                        w_state_nxt      = MATCH_OVER;
                    end else begin
                        w_hold_nxt  = HOLD_INIT;
                        w_state_nxt = HOLD;
                    end
                end else begin
                    w_round_reset_nxt = 1'b0;
                end
            end

            HOLD: begin
                if (r_hold == '0) begin
                    w_round_reset_nxt = 1'b0;
                    w_state_nxt       = PLAY;
                end else begin
                    w_hold_nxt = r_hold - HOLD_W'(1);
                end
            end

            MATCH_OVER: begin
                // Keep the playfield frozen until a fresh match starts.
                w_round_reset_nxt = 1'b1;
`ifdef TUG_SCOREBOARD_NEW_MATCH_EN
                if (bus.new_match) begin
                    w_left_score_nxt  = '0;
                    w_right_score_nxt = '0;
                    w_round_reset_nxt = 1'b0;
                    w_match_over_nxt  = 1'b0;
                    w_winner_nxt      = PLAYER_LEFT;
                    w_state_nxt       = PLAY;
                end
`endif
            end

            default: begin
                w_state_nxt = PLAY;
            end
        endcase
    end

    assign bus.left_score  = r_left_score;
    assign bus.right_score = r_right_score;
    assign bus.round_reset = r_round_reset;
    assign bus.match_over  = r_match_over;
    assign bus.winner      = r_winner;

endmodule

// File: tb/tb_tug_scoreboard.sv
// Self-checking bench for tug_scoreboard: directed scenarios plus randomized play against a round-level model.
// Latency: checks every output one cycle after the inputs that cause it.
// Backpressure: n/a. Macro TUG_SCOREBOARD_NEW_MATCH_EN enables the new_match scenario.
module tb_tug_scoreboard;

    localparam int MAX_SCORE   = 7;
    localparam int HOLD_CYCLES = 4;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    tug_scoreboard_if bus ();

    tug_scoreboard #(
        .MAX_SCORE   (MAX_SCORE),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-level reference: scores, remaining freeze cycles, match result.
    int m_ls, m_rs, m_hold_left;
    bit m_over, m_win, m_pl, m_pr;

    task automatic model_reset();
        m_ls = 0; m_rs = 0; m_hold_left = 0;
        m_over = 0; m_win = 0; m_pl = 0; m_pr = 0;
    endtask

    task automatic model_edge(input bit lw, input bit rw, input bit nm);
        bit el, er;
        el = lw && !m_pl;
        er = rw && !m_pr;
        m_pl = lw;
        m_pr = rw;
        if (m_over) begin
`ifdef TUG_SCOREBOARD_NEW_MATCH_EN
            if (nm) begin
                m_ls = 0; m_rs = 0; m_over = 0; m_win = 0;
            end
`endif
        end else if (m_hold_left > 0) begin
            m_hold_left--;
        end else if (el && er) begin
            m_hold_left = HOLD_CYCLES;
        end else if (el || er) begin
            if (el) m_ls++; else m_rs++;
            if ((el ? m_ls : m_rs) == MAX_SCORE) begin
                m_over = 1;
                m_win  = er;
            end else begin
                m_hold_left = HOLD_CYCLES;
            end
        end
    endtask

    // Called at posedge+1: drive inputs for one cycle, advance DUT and model.
    task automatic step(input bit lw, input bit rw, input bit nm = 1'b0);
        bus.left_win  = lw;
        bus.right_win = rw;
`ifdef TUG_SCOREBOARD_NEW_MATCH_EN
        bus.new_match = nm;
`endif
        @(posedge clk);
        model_edge(lw, rw, nm);
        #1;
    endtask

    task automatic do_reset();
        bus.left_win  = 1'b0;
        bus.right_win = 1'b0;
`ifdef TUG_SCOREBOARD_NEW_MATCH_EN
        bus.new_match = 1'b0;
`endif
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus.left_score !== 3'd0 || bus.right_score !== 3'd0 || bus.round_reset !== 1'b0 ||
            bus.match_over !== 1'b0 || bus.winner !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got ls=%0d rs=%0d rr=%b mo=%b w=%b, want all 0",
                     bus.left_score, bus.right_score, bus.round_reset, bus.match_over, bus.winner);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_left();
        do_reset();
        for (int i = 0; i < 9; i++) step(0, 0);
        step(1, 0);
        n_tests++;
        if (bus.left_score !== 3'd1 || bus.round_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL single_left_latency: got ls=%0d rr=%b, want ls=1 rr=1",
                     bus.left_score, bus.round_reset);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            n_tests++;
            if (bus.round_reset !== 1'b1) begin
                n_fail++;
                $display("FAIL single_left_hold%0d: got rr=%b, want 1", i, bus.round_reset);
            end
        end
        step(0, 0);
        n_tests++;
        if (bus.round_reset !== 1'b0 || bus.left_score !== 3'd1 || bus.right_score !== 3'd0) begin
            n_fail++;
            $display("FAIL single_left_release: got rr=%b ls=%0d rs=%0d, want rr=0 ls=1 rs=0",
                     bus.round_reset, bus.left_score, bus.right_score);
        end
    endtask

    task automatic test_held_right();
        int rr_cnt;
        rr_cnt = 0;
        do_reset();
        for (int i = 0; i < 10; i++) step(0, 0);
        for (int i = 0; i < 21; i++) begin
            step(0, 1);
            if (bus.round_reset === 1'b1) rr_cnt++;
        end
        for (int i = 0; i < 3; i++) step(0, 0);
        n_tests++;
        if (bus.right_score !== 3'd1 || bus.left_score !== 3'd0) begin
            n_fail++;
            $display("FAIL held_right_score: got rs=%0d ls=%0d, want rs=1 ls=0",
                     bus.right_score, bus.left_score);
        end
        n_tests++;
        if (rr_cnt != HOLD_CYCLES) begin
            n_fail++;
            $display("FAIL held_right_rr_len: got %0d cycles, want %0d", rr_cnt, HOLD_CYCLES);
        end
    endtask

    task automatic test_tie();
        int rr_cnt;
        rr_cnt = 0;
        do_reset();
        step(0, 0);
        step(1, 1);
        if (bus.round_reset === 1'b1) rr_cnt++;
        for (int i = 0; i < 7; i++) begin
            step(0, 0);
            if (bus.round_reset === 1'b1) rr_cnt++;
        end
        n_tests++;
        if (bus.left_score !== 3'd0 || bus.right_score !== 3'd0 || rr_cnt != HOLD_CYCLES) begin
            n_fail++;
            $display("FAIL tie: got ls=%0d rs=%0d rr_cycles=%0d, want 0 0 %0d",
                     bus.left_score, bus.right_score, rr_cnt, HOLD_CYCLES);
        end
    endtask

    task automatic test_match_left();
        do_reset();
        step(0, 0);
        for (int w = 0; w < MAX_SCORE; w++) begin
            step(1, 0);
            for (int i = 0; i < HOLD_CYCLES + 1; i++) step(0, 0);
        end
        n_tests++;
        if (bus.left_score !== 3'd7 || bus.match_over !== 1'b1 || bus.winner !== 1'b0 ||
            bus.round_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL match_left: got ls=%0d mo=%b w=%b rr=%b, want 7 1 0 1",
                     bus.left_score, bus.match_over, bus.winner, bus.round_reset);
        end
        step(0, 1);
        step(0, 0);
        step(1, 0);
        step(0, 0);
        n_tests++;
        if (bus.right_score !== 3'd0 || bus.left_score !== 3'd7 || bus.match_over !== 1'b1 ||
            bus.round_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL match_frozen: got ls=%0d rs=%0d mo=%b rr=%b, want 7 0 1 1",
                     bus.left_score, bus.right_score, bus.match_over, bus.round_reset);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        step(0, 0);
        step(0, 1);
        step(0, 0);
        n_tests++;
        if (bus.round_reset !== 1'b1 || bus.right_score !== 3'd1) begin
            n_fail++;
            $display("FAIL mid_hold_setup: got rr=%b rs=%0d, want 1 1", bus.round_reset, bus.right_score);
        end
        bus.right_win = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (bus.left_score !== 3'd0 || bus.right_score !== 3'd0 || bus.round_reset !== 1'b0 ||
            bus.match_over !== 1'b0 || bus.winner !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_hold_async_reset: got ls=%0d rs=%0d rr=%b mo=%b w=%b, want all 0",
                     bus.left_score, bus.right_score, bus.round_reset, bus.match_over, bus.winner);
        end
        #1;
        reset = 1'b0;
        step(0, 0);
        step(1, 0);
        n_tests++;
        if (bus.left_score !== 3'd1 || bus.right_score !== 3'd0 || bus.round_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_win: got ls=%0d rs=%0d rr=%b, want 1 0 1",
                     bus.left_score, bus.right_score, bus.round_reset);
        end
    endtask

`ifdef TUG_SCOREBOARD_NEW_MATCH_EN
    task automatic test_new_match();
        do_reset();
        step(0, 0);
        for (int w = 0; w < MAX_SCORE; w++) begin
            step(0, 1);
            for (int i = 0; i < HOLD_CYCLES + 1; i++) step(0, 0);
        end
        n_tests++;
        if (bus.match_over !== 1'b1 || bus.winner !== 1'b1 || bus.right_score !== 3'd7) begin
            n_fail++;
            $display("FAIL new_match_setup: got mo=%b w=%b rs=%0d, want 1 1 7",
                     bus.match_over, bus.winner, bus.right_score);
        end
        step(0, 0, 1);
        n_tests++;
        if (bus.left_score !== 3'd0 || bus.right_score !== 3'd0 || bus.match_over !== 1'b0 ||
            bus.round_reset !== 1'b0 || bus.winner !== 1'b0) begin
            n_fail++;
            $display("FAIL new_match_clear: got ls=%0d rs=%0d mo=%b rr=%b w=%b, want all 0",
                     bus.left_score, bus.right_score, bus.match_over, bus.round_reset, bus.winner);
        end
        step(1, 0);
        n_tests++;
        if (bus.left_score !== 3'd1 || bus.round_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL new_match_rescore: got ls=%0d rr=%b, want 1 1", bus.left_score, bus.round_reset);
        end
    endtask
`endif

    task automatic test_random();
        bit lw, rw, nm;
        bit exp_rr, exp_w;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 399) do_reset();
            lw = ($urandom_range(0, 3) == 0);
            rw = ($urandom_range(0, 3) == 0);
            nm = ($urandom_range(0, 15) == 0);
            step(lw, rw, nm);
            exp_rr = m_over || (m_hold_left > 0);
            exp_w  = m_over ? m_win : 1'b0;
            n_tests++;
            if (bus.left_score !== 3'(m_ls) || bus.right_score !== 3'(m_rs) ||
                bus.round_reset !== exp_rr || bus.match_over !== m_over || bus.winner !== exp_w) begin
                n_fail++;
                $display("FAIL random_c%0d: got ls=%0d rs=%0d rr=%b mo=%b w=%b, want ls=%0d rs=%0d rr=%b mo=%b w=%b",
                         c, bus.left_score, bus.right_score, bus.round_reset, bus.match_over, bus.winner,
                         m_ls, m_rs, exp_rr, m_over, exp_w);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.left_win  = 1'b0;
        bus.right_win = 1'b0;
`ifdef TUG_SCOREBOARD_NEW_MATCH_EN
        bus.new_match = 1'b0;
`endif
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_single_left();
        test_held_right();
        test_tie();
        test_match_left();
        test_reset_mid_hold();
`ifdef TUG_SCOREBOARD_NEW_MATCH_EN
        test_new_match();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
